// File: rtl/clock_period_meter_if.sv
// Signal bundle between the period meter and its consumer: enable and the measured
// input go in, measurement results come out. The in_range line exists only with PERIOD_CHECK_EN.
interface clock_period_meter_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             clk_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;
`ifdef PERIOD_CHECK_EN
    logic             in_range;

    modport master (
        output enable, clk_in,
        input  period, high_time, valid, locked, timeout, in_range
    );
    modport slave (
        input  enable, clk_in,
        output period, high_time, valid, locked, timeout, in_range
    );
`else
    modport master (
        output enable, clk_in,
        input  period, high_time, valid, locked, timeout
    );
    modport slave (
        input  enable, clk_in,
        output period, high_time, valid, locked, timeout
    );
`endif
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in i_clk cycles and flags loss.
// Optional macro PERIOD_CHECK_EN adds an in_range flag comparing each period against EXP_PERIOD +/- TOL.
module clock_period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 200_000_000,
    parameter int SYNC_STAGES = 2
`ifdef PERIOD_CHECK_EN
    ,
    parameter int EXP_PERIOD  = 100_000_000,
    parameter int TOL         = 1000
`endif
) (
    input  logic                 i_clk,
    input  logic                 reset_n,
    clock_period_meter_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hcnt;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high_time;
    logic                   r_valid;
    logic                   r_locked;
    logic                   r_timeout;

    logic                   w_lvl;
    logic                   w_rise;
    logic                   w_last;
    logic [CNT_W-1:0]       w_period_new;
    logic [CNT_W-1:0]       w_high_new;

    assign w_lvl        = r_sync[SYNC_STAGES-1];
    assign w_rise       = w_lvl & ~r_prev;
    assign w_last       = (r_cnt == C_LAST);
    assign w_period_new = r_cnt + CNT_W'(1);
    assign w_high_new   = r_hcnt + CNT_W'(w_lvl);

`ifdef PERIOD_CHECK_EN
    localparam logic [CNT_W-1:0] C_EXP = CNT_W'(EXP_PERIOD);

    logic                   r_in_range;
    logic signed [CNT_W:0]  w_diff;
    logic [CNT_W:0]         w_abs;
    logic                   w_in_range;

    // One extra bit keeps the signed difference exact for any pair of CNT_W-bit values.
    assign w_diff     = $signed({1'b0, w_period_new}) - $signed({1'b0, C_EXP});
    assign w_abs      = w_diff[CNT_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_in_range = (w_abs <= (CNT_W+1)'(TOL));
    assign bus.in_range = r_in_range;
`endif

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.clk_in};
            r_prev <= w_lvl;
        end
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef PERIOD_CHECK_EN
            r_in_range  <= 1'b0;
`endif
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            if (!bus.enable) begin
                // Disabling drops lock silently; the last measurement stays visible.
                r_state  <= IDLE;
                r_locked <= 1'b0;
                r_cnt    <= '0;
                r_hcnt   <= '0;
`ifdef PERIOD_CHECK_EN
                r_in_range <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt   <= '0;
                        r_hcnt  <= '0;
                        r_state <= ARM;
                    end
                    ARM: begin
                        if (w_rise) begin
                            r_cnt   <= '0;
                            r_hcnt  <= '0;
                            r_state <= MEASURE;
                        end else if (w_last) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
`ifdef PERIOD_CHECK_EN
                            r_in_range <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    MEASURE: begin
                        // An edge landing on the threshold cycle still completes the measurement.
                        if (w_rise) begin
                            r_period    <= w_period_new;
                            r_high_time <= w_high_new;
                            r_valid     <= 1'b1;
                            r_locked    <= 1'b1;
                            r_cnt       <= '0;
                            r_hcnt      <= '0;
`ifdef PERIOD_CHECK_EN
                            r_in_range  <= w_in_range;
`endif
                        end else if (w_last) begin
                            r_timeout <= 1'b1;
                            r_locked  <= 1'b0;
                            r_cnt     <= '0;
                            r_hcnt    <= '0;
                            r_state   <= ARM;
`ifdef PERIOD_CHECK_EN
                            r_in_range <= 1'b0;
`endif
                        end else begin
                            r_cnt  <= w_period_new;
                            r_hcnt <= w_high_new;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_hcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.period    = r_period;
    assign bus.high_time = r_high_time;
    assign bus.valid     = r_valid;
    assign bus.locked    = r_locked;
    assign bus.timeout   = r_timeout;
endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Receive side of the slow divided-clock interface: samples a slow, asynchronous square wave (e.g. the 1 Hz blink clock) in the 100 MHz `i_clk` domain.
- Measures its period and high time in `i_clk` cycles and flags loss of the signal.
- Sits beside the divider/LED path so firmware or a checker can confirm the produced frequency and duty cycle.

Parameters:
- CNT_W, 32, width of the cycle counters and of the `period`/`high_time` outputs.
- TIMEOUT, 200_000_000, max `i_clk` cycles between rising edges before the signal is declared lost. Must satisfy TIMEOUT < 2^CNT_W.
- SYNC_STAGES, 2, number of synchroniser flops on `clk_in`. Legal range 2..4.

Ports:
- i_clk  input  1  100 MHz system clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  measurement enable (synchronous to `i_clk`).
- clk_in  input  1  measured signal, asynchronous to `i_clk`.
- period  output  CNT_W  last measured period, in `i_clk` cycles.
- high_time  output  CNT_W  `i_clk` cycles the synchronised level was high within that period.
- valid  output  1  one-cycle pulse when `period`/`high_time` update.
- locked  output  1  high while consecutive edges arrive within TIMEOUT.
- timeout  output  1  one-cycle pulse when signal loss is detected.

Behaviour:
- Reset (async assert, sync release): all outputs 0, all counters 0, synchroniser flops 0, state IDLE.
- Input path:
  - `clk_in` passes through SYNC_STAGES flops to give `s_lvl`, then one more flop gives `s_prev`.
  - `rise = s_lvl & ~s_prev`.
  - With SYNC_STAGES=2, a `clk_in` rising edge produces `rise` 2-3 cycles later.
- State machine:
  - IDLE:
    - `cnt` and `hcnt` are held at 0.
    - Transition: `enable` = 1 -> ARM.
  - ARM (waiting for the first edge):
    - `cnt` increments each cycle.
    - On `rise`: `cnt` <= 0, `hcnt` <= 0, next state MEASURE.
    - If `cnt` reaches TIMEOUT-1 with no `rise`: pulse `timeout`, `cnt` <= 0, stay in ARM.
  - MEASURE:
    - Each cycle: `cnt` <= `cnt`+1, and `hcnt` <= `hcnt`+`s_lvl`.
    - On `rise`:
      - `period` <= `cnt`+1.
      - `high_time` <= `hcnt`+`s_lvl`.
      - `valid` = 1 for that single cycle (the outputs and `valid` appear together, one cycle after `rise`).
      - `locked` <= 1.
      - `cnt` <= 0, `hcnt` <= 0, stay in MEASURE.
    - If `cnt` reaches TIMEOUT-1 with no `rise`:
      - pulse `timeout`, `locked` <= 0.
      - `period` and `high_time` hold their last values.
      - next state ARM.
- Simultaneous `rise` and timeout threshold in the same cycle: the edge wins, and the measurement completes normally.
- `enable` deasserted in any state:
  - next cycle -> IDLE, `locked` <= 0.
  - `period`/`high_time` hold their values.
  - no `valid` or `timeout` pulse is generated.
- `enable` reasserted: re-enters ARM. The first edge after ARM never produces `valid`, so a partial period is never reported.
- Counters never exceed TIMEOUT-1, so no wrap-around is possible. `hcnt` ≤ `cnt`+1 always.
- Glitches shorter than one `i_clk` cycle may be missed. This is accepted and not flagged.

Optional Feature:
- Macro: PERIOD_CHECK_EN.
- When defined:
  - Extra parameters: EXP_PERIOD (default 100_000_000) and TOL (default 1000).
  - Extra output `in_range` (1 bit, reset 0).
  - `in_range` updates in the same cycle as `valid`: 1 iff |`period`_new − EXP_PERIOD| ≤ TOL. The subtraction is done in CNT_W+1 bits, signed.
  - `in_range` clears to 0 on `timeout` and on `enable` deassert.
- When not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: drive `reset_n`=0 mid-operation while in MEASURE (`locked`=1). Required: all outputs go to 0 immediately, without waiting for an `i_clk` edge. After release with `enable`=1 the block restarts from ARM.
- Steady square wave: TIMEOUT=100, `clk_in` period 20 `i_clk` cycles, high 8 cycles. Required:
  - no `valid` after the first edge;
  - from the second edge onward, each edge gives `valid` pulses with `period`=20, `high_time`=8, `locked`=1.
- Signal loss: TIMEOUT=100, after lock hold `clk_in` at 0. Required:
  - `timeout` pulses exactly 100 cycles after the last `cnt` clear;
  - `locked`=0 and `period` holds 20;
  - `timeout` repeats every 100 cycles while in ARM.
- Edge at threshold: place a `rise` in the same cycle `cnt`=TIMEOUT-1. Required: `valid` with `period`=TIMEOUT, no `timeout` pulse, `locked` stays 1.
- Enable toggle: deassert `enable` for 5 cycles mid-period, then reassert. Required:
  - `locked`=0 with no pulses while disabled;
  - the first `valid` arrives after two new edges, with correct `period`=20.
- PERIOD_CHECK_EN: EXP_PERIOD=20, TOL=1. Required:
  - periods 19, 20, 21 give `in_range`=1;
  - periods 18 and 22 give `in_range`=0;
  - after a `timeout`, `in_range`=0.
